// File: rtl/stream_pack_fifo.sv
// Packs IN_W-bit samples into RATIO-sample host words, buffers them in a single-clock FIFO
// and serves them to a host read pipe with sticky overflow, EOF and a saturating drop counter.
module stream_pack_fifo #(
    parameter int IN_W       = 16,
    parameter int RATIO      = 2,
    parameter int DEPTH_LOG2 = 11,
    parameter int FIRST_LSB  = 1,
    parameter int DROP_W     = 16
) (
    input  logic                    bus_clk,
    input  logic                    reset,
    input  logic [IN_W-1:0]         in_data,
    input  logic                    in_wen,
    input  logic                    in_flush,
    input  logic                    user_r_open,
    input  logic                    user_r_rden,
    output logic [IN_W*RATIO-1:0]   user_r_data,
    output logic                    user_r_empty,
    output logic                    user_r_eof,
    output logic                    fifo_overflow,
    output logic [DROP_W-1:0]       drop_count,
    output logic [DEPTH_LOG2:0]     fifo_level
);

    localparam int OUT_W = IN_W * RATIO;
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int CNT_W = $clog2(RATIO + 1);
    localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DROP_W-1:0]   DROP_MAX = '1;

    logic [OUT_W-1:0]       r_mem [DEPTH];
    logic [OUT_W-1:0]       r_pack;
    logic [CNT_W-1:0]       r_slot;
    logic [DEPTH_LOG2-1:0]  r_wr_ptr;
    logic [DEPTH_LOG2-1:0]  r_rd_ptr;
    logic [DEPTH_LOG2:0]    r_level;
    logic                   r_empty;
    logic                   r_ovf;
    logic [DROP_W-1:0]      r_drop;
    logic [OUT_W-1:0]       r_data;

    logic                   w_clr;
    logic                   w_acc;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_push_req;
    logic                   w_push_ok;
    logic                   w_push_blk;
    logic                   w_reject;
    logic [CNT_W-1:0]       w_count;
    logic [OUT_W-1:0]       w_word;
    logic [DEPTH_LOG2:0]    w_level_nxt;
    logic [CNT_W-1:0]       w_drop_inc;
    logic [DROP_W:0]        w_drop_sum;
    logic [DROP_W-1:0]      w_drop_nxt;

    // Bit position of slot s inside a host word.
    function automatic int slot_pos(input int s);
        return (FIRST_LSB != 0) ? (s * IN_W) : ((RATIO - 1 - s) * IN_W);
    endfunction

    assign w_clr      = reset | ~user_r_open;
    assign w_acc      = in_wen & ~r_ovf & ~w_clr;
    assign w_count    = r_slot + CNT_W'(w_acc);
    assign w_pop      = user_r_rden & ~r_empty & ~w_clr;
    assign w_full     = (r_level == FULL_LVL);
    // A word leaves the packer when full, or on flush if it holds at least one sample.
    assign w_push_req = ~w_clr & ~r_ovf &
                        ((w_count == CNT_W'(RATIO)) | (in_flush & (w_count != '0)));
    assign w_push_ok  = w_push_req & (~w_full | w_pop);
    assign w_push_blk = w_push_req & w_full & ~w_pop;
    assign w_reject   = ~w_clr & r_ovf & in_wen;

    // Current pack register with the accepted sample merged into its slot.
    always_comb begin
        w_word = r_pack;
        for (int s = 0; s < RATIO; s++) begin
            w_word[slot_pos(s) +: IN_W] = (w_acc && (r_slot == CNT_W'(s))) ?
                                          in_data : r_pack[slot_pos(s) +: IN_W];
        end
    end

    // Next FIFO occupancy from push/pop outcome.
    always_comb begin
        case ({w_push_ok, w_pop})
            2'b10:   w_level_nxt = r_level + (DEPTH_LOG2 + 1)'(1);
            2'b01:   w_level_nxt = r_level - (DEPTH_LOG2 + 1)'(1);
            default: w_level_nxt = r_level;
        endcase
    end

    // Drop increment: whole discarded word on a blocked push, one per rejected sample.
    always_comb begin
        if (w_push_blk) begin
            w_drop_inc = w_count;
        end else if (w_reject) begin
            w_drop_inc = CNT_W'(1);
        end else begin
            w_drop_inc = '0;
        end
        w_drop_sum = {1'b0, r_drop} + (DROP_W + 1)'(w_drop_inc);
        w_drop_nxt = w_drop_sum[DROP_W] ? DROP_MAX : w_drop_sum[DROP_W-1:0];
    end

    // Pack register and slot counter; frozen while overflowed.
    always_ff @(posedge bus_clk) begin
        if (w_clr) begin
            r_pack <= '0;
            r_slot <= '0;
        end else if (w_push_req) begin
            r_pack <= '0;
            r_slot <= '0;
        end else if (w_acc) begin
            r_pack <= w_word;
            r_slot <= w_count;
        end else begin
            r_pack <= r_pack;
            r_slot <= r_slot;
        end
    end

    // FIFO storage; contents need no reset since pointers define validity.
    always_ff @(posedge bus_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= w_word;
        end
    end

    // Pointers, level, empty flag and read data register.
    always_ff @(posedge bus_clk) begin
        if (w_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_empty  <= 1'b1;
            r_data   <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
                r_data   <= r_mem[r_rd_ptr];
            end
            r_level <= w_level_nxt;
            r_empty <= (w_level_nxt == '0);
        end
    end

    // Sticky overflow flag and saturating drop counter.
    always_ff @(posedge bus_clk) begin
        if (w_clr) begin
            r_ovf  <= 1'b0;
            r_drop <= '0;
        end else begin
            r_ovf  <= r_ovf | w_push_blk;
            r_drop <= w_drop_nxt;
        end
    end

    assign user_r_data   = r_data;
    assign user_r_empty  = r_empty;
    assign user_r_eof    = r_ovf & r_empty;
    assign fifo_overflow = r_ovf;
    assign drop_count    = r_drop;
    assign fifo_level    = r_level;

endmodule
